// File: rtl/n_bit_comparator.sv
// n_bit_comparator: registered magnitude comparator for two N-bit operands.
// A compare presented with in_valid=1 at a rising edge is reported on the
// one-hot lesser/greater/equal flags, with out_valid=1, right after that edge.
//
// Handshake: in_valid qualifies a and b for exactly the edge it is high at.
// There is no ready; the block accepts one compare every cycle. out_valid is
// high for the single cycle following each accepted compare. The flags keep
// the last result while out_valid is low.
//
// Optional feature macro: N_BIT_COMPARATOR_STATS_EN.
// When it is defined the block gains stats_clr and three 16-bit saturating
// result counters (lt_count, gt_count, eq_count).
module n_bit_comparator #(
  parameter int N      = 9,
  parameter int SIGNED = 0
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         in_valid,
  input  logic [N-1:0] a,
  input  logic [N-1:0] b,
`ifdef N_BIT_COMPARATOR_STATS_EN
  input  logic         stats_clr,
  output logic [15:0]  lt_count,
  output logic [15:0]  gt_count,
  output logic [15:0]  eq_count,
`endif
  output logic         out_valid,
  output logic         lesser,
  output logic         greater,
  output logic         equal
);

  // Inverting the sign bit maps two's-complement order onto unsigned order,
  // so one unsigned comparator serves both modes.
  logic [N-1:0] sign_flip;
  logic [N-1:0] a_key;
  logic [N-1:0] b_key;
  logic         lt_c;
  logic         gt_c;
  logic         eq_c;

  // Combinational compare of the current operands.
  always_comb begin
    sign_flip        = '0;
    sign_flip[N-1]   = (SIGNED != 0);
    a_key            = a ^ sign_flip;
    b_key            = b ^ sign_flip;
    lt_c             = (a_key < b_key);
    gt_c             = (a_key > b_key);
    eq_c             = (a == b);
  end

  logic out_valid_q, out_valid_d;
  logic lesser_q,    lesser_d;
  logic greater_q,   greater_d;
  logic equal_q,     equal_d;

  // Next-state for the flags: load on a valid compare, otherwise hold.
  // Operand values are never looked at unless in_valid is high.
  always_comb begin
    out_valid_d = in_valid;
    lesser_d    = lesser_q;
    greater_d   = greater_q;
    equal_d     = equal_q;
    if (in_valid) begin
      lesser_d  = lt_c;
      greater_d = gt_c;
      equal_d   = eq_c;
    end
  end

  // Flag registers; reset discards any in-flight result.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      out_valid_q <= 1'b0;
      lesser_q    <= 1'b0;
      greater_q   <= 1'b0;
      equal_q     <= 1'b0;
    end else begin
      out_valid_q <= out_valid_d;
      lesser_q    <= lesser_d;
      greater_q   <= greater_d;
      equal_q     <= equal_d;
    end
  end

  assign out_valid = out_valid_q;
  assign lesser    = lesser_q;
  assign greater   = greater_q;
  assign equal     = equal_q;

`ifdef N_BIT_COMPARATOR_STATS_EN
  localparam logic [15:0] CNT_MAX = 16'hFFFF;

  logic [15:0] lt_count_q, lt_count_d;
  logic [15:0] gt_count_q, gt_count_d;
  logic [15:0] eq_count_q, eq_count_d;

  // Counter next-state: clear has priority, increments saturate at all-ones.
  always_comb begin
    lt_count_d = lt_count_q;
    gt_count_d = gt_count_q;
    eq_count_d = eq_count_q;
    if (stats_clr) begin
      lt_count_d = '0;
      gt_count_d = '0;
      eq_count_d = '0;
    end else if (in_valid) begin
      if (lt_c && (lt_count_q != CNT_MAX)) lt_count_d = lt_count_q + 16'd1;
      if (gt_c && (gt_count_q != CNT_MAX)) gt_count_d = gt_count_q + 16'd1;
      if (eq_c && (eq_count_q != CNT_MAX)) eq_count_d = eq_count_q + 16'd1;
    end
  end

  // Counter registers, updated on the same edge as the flags.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      lt_count_q <= '0;
      gt_count_q <= '0;
      eq_count_q <= '0;
    end else begin
      lt_count_q <= lt_count_d;
      gt_count_q <= gt_count_d;
      eq_count_q <= eq_count_d;
    end
  end

  assign lt_count = lt_count_q;
  assign gt_count = gt_count_q;
  assign eq_count = eq_count_q;
`endif

endmodule

// File: tb/tb_n_bit_comparator.sv
// Bench for n_bit_comparator: one unsigned and one signed instance (N=9)
// share the same stimulus and are checked every cycle against an
// integer-arithmetic model, plus hand-computed literal expectations.
// Counter checks apply when N_BIT_COMPARATOR_STATS_EN is defined.
module tb_n_bit_comparator;

  localparam int N = 9;

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  logic rst_n = 1'b1;
  always #5 clk = ~clk;

  logic         in_valid = 1'b0;
  logic [N-1:0] a = '0;
  logic [N-1:0] b = '0;

  logic u_ov, u_lt, u_gt, u_eq;
  logic s_ov, s_lt, s_gt, s_eq;

`ifdef N_BIT_COMPARATOR_STATS_EN
  logic        stats_clr = 1'b0;
  logic [15:0] u_ltc, u_gtc, u_eqc;
  logic [15:0] s_ltc, s_gtc, s_eqc;
`endif

  n_bit_comparator #(.N(N), .SIGNED(0)) u_dut (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .a(a), .b(b),
`ifdef N_BIT_COMPARATOR_STATS_EN
    .stats_clr(stats_clr), .lt_count(u_ltc), .gt_count(u_gtc), .eq_count(u_eqc),
`endif
    .out_valid(u_ov), .lesser(u_lt), .greater(u_gt), .equal(u_eq)
  );

  n_bit_comparator #(.N(N), .SIGNED(1)) s_dut (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .a(a), .b(b),
`ifdef N_BIT_COMPARATOR_STATS_EN
    .stats_clr(stats_clr), .lt_count(s_ltc), .gt_count(s_gtc), .eq_count(s_eqc),
`endif
    .out_valid(s_ov), .lesser(s_lt), .greater(s_gt), .equal(s_eq)
  );

  // ---------------- scoreboard counters ----------------
  int n_vec = 0;
  int n_err = 0;

  task automatic chk4(input string nm, input logic [3:0] act, input logic [3:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got {ov,lt,gt,eq}=%b expected %b at %0t", nm, act, exp, $time);
    end
  endtask

  task automatic chk48(input string nm, input logic [47:0] act, input logic [47:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got lt/gt/eq=%0d/%0d/%0d expected %0d/%0d/%0d at %0t", nm,
               act[47:32], act[31:16], act[15:0], exp[47:32], exp[31:16], exp[15:0], $time);
    end
  endtask

  // ---------------- behavioural model ----------------
  // Operands are turned into integers according to the mode and ordered with
  // plain integer relations.
  function automatic int to_num(input logic [N-1:0] v, input bit sgn);
    int r;
    r = int'(v);
    if (sgn && v[N-1]) r = r - (1 << N);
    return r;
  endfunction

  logic       exp_ov = 1'b0;
  logic [2:0] exp_f [2];     // {lt,gt,eq} per instance: 0 unsigned, 1 signed
  int         cnt   [2][3];  // lt, gt, eq counts per instance

  initial begin
    exp_f[0] = 3'b000;
    exp_f[1] = 3'b000;
    for (int i = 0; i < 2; i++) for (int j = 0; j < 3; j++) cnt[i][j] = 0;
  end

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      exp_ov = 1'b0;
      for (int i = 0; i < 2; i++) begin
        exp_f[i] = 3'b000;
        for (int j = 0; j < 3; j++) cnt[i][j] = 0;
      end
    end else begin
      exp_ov = in_valid;
      for (int i = 0; i < 2; i++) begin
        int x, y, k;
        x = to_num(a, i == 1);
        y = to_num(b, i == 1);
        k = (x < y) ? 0 : ((x > y) ? 1 : 2);
        if (in_valid) begin
          exp_f[i] = 3'b000;
          exp_f[i][2 - k] = 1'b1;
        end
`ifdef N_BIT_COMPARATOR_STATS_EN
        if (stats_clr) begin
          for (int j = 0; j < 3; j++) cnt[i][j] = 0;
        end else if (in_valid && cnt[i][k] < 65535) begin
          cnt[i][k] = cnt[i][k] + 1;
        end
`endif
      end
    end
  end

  // Per-cycle compare of both instances against the model.
  always @(negedge clk) begin
    chk4("u_cycle", {u_ov, u_lt, u_gt, u_eq}, {exp_ov, exp_f[0]});
    chk4("s_cycle", {s_ov, s_lt, s_gt, s_eq}, {exp_ov, exp_f[1]});
`ifdef N_BIT_COMPARATOR_STATS_EN
    chk48("u_cnt_cycle", {u_ltc, u_gtc, u_eqc},
          {cnt[0][0][15:0], cnt[0][1][15:0], cnt[0][2][15:0]});
    chk48("s_cnt_cycle", {s_ltc, s_gtc, s_eqc},
          {cnt[1][0][15:0], cnt[1][1][15:0], cnt[1][2][15:0]});
`endif
  end

  // ---------------- driver tasks ----------------
  // Inputs change 2 time units after a rising edge; they are captured at the
  // following edge.
  task automatic step(input logic [N-1:0] va, input logic [N-1:0] vb,
                      input logic vv, input logic clr = 1'b0);
    @(posedge clk);
    #2;
    a = va;
    b = vb;
    in_valid = vv;
`ifdef N_BIT_COMPARATOR_STATS_EN
    stats_clr = clr;
`else
    if (clr) $display("note: stats_clr ignored without counters");
`endif
  endtask

  // Checks outputs just after the next edge (3 units past it).
  task automatic expect_lit(input string nm, input logic [3:0] u_exp, input logic [3:0] s_exp);
    @(posedge clk);
    #3;
    chk4({nm, "_u"}, {u_ov, u_lt, u_gt, u_eq}, u_exp);
    chk4({nm, "_s"}, {s_ov, s_lt, s_gt, s_eq}, s_exp);
  endtask

  // Back-to-back table, including range boundaries.
  logic [N-1:0] bb_a [8] = '{9'd0,   9'd511, 9'd255, 9'd256, 9'd1,   9'd100, 9'd257, 9'd42};
  logic [N-1:0] bb_b [8] = '{9'd0,   9'd0,   9'd256, 9'd255, 9'd511, 9'd100, 9'd256, 9'd43};

  // ---------------- main sequence ----------------
  initial begin
    #1 rst_n = 1'b0;
    #1 chk4("reset_u", {u_ov, u_lt, u_gt, u_eq}, 4'b0000);
    chk4("reset_s", {s_ov, s_lt, s_gt, s_eq}, 4'b0000);
    repeat (2) @(posedge clk);
    #2 rst_n = 1'b1;

    // Idle after release: outputs stay zero.
    repeat (5) step(9'd77, 9'd3, 1'b0);
    expect_lit("idle", 4'b0000, 4'b0000);

    // 300 vs 12: unsigned greater; signed 300 is -212, so lesser.
    step(9'd300, 9'd12, 1'b1);
    expect_lit("u300_12", 4'b1010, 4'b1100);
    // 0 vs 511: unsigned lesser; signed 0 > -1.
    step(9'd0, 9'd511, 1'b1);
    expect_lit("u0_511", 4'b1100, 4'b1010);
    step(9'd511, 9'd511, 1'b1);
    expect_lit("eq511", 4'b1001, 4'b1001);
    // -1 vs 1 and -256 vs 255.
    step(9'h1FF, 9'h001, 1'b1);
    expect_lit("m1_1", 4'b1010, 4'b1100);
    step(9'h100, 9'h0FF, 1'b1);
    expect_lit("m256_255", 4'b1010, 4'b1100);
    step(9'h100, 9'h100, 1'b1);
    expect_lit("eq_m256", 4'b1001, 4'b1001);

    // Back-to-back compares, one per cycle; checked by the per-cycle compare.
    for (int i = 0; i < 8; i++) step(bb_a[i], bb_b[i], 1'b1);

    // Hold: a valid greater, then invalid operands that would give lesser.
    step(9'd5, 9'd3, 1'b1);
    step(9'd1, 9'd9, 1'b0);
    expect_lit("hold", 4'b0010, 4'b0010);

    // Reset mid-operation.
    step(9'd7, 9'd7, 1'b1);
    @(posedge clk);
    #1 chk4("pre_rst_u", {u_ov, u_lt, u_gt, u_eq}, 4'b1001);
    #1 in_valid = 1'b0;
    rst_n = 1'b0;
    #1 chk4("async_rst_u", {u_ov, u_lt, u_gt, u_eq}, 4'b0000);
    chk4("async_rst_s", {s_ov, s_lt, s_gt, s_eq}, 4'b0000);
    #4 rst_n = 1'b1;
    step(9'd2, 9'd8, 1'b1);
    expect_lit("after_rst", 4'b1100, 4'b1100);
    step(9'd0, 9'd0, 1'b0);

`ifdef N_BIT_COMPARATOR_STATS_EN
    step(9'd0, 9'd0, 1'b0, 1'b1);
    step(9'd5, 9'd3, 1'b1);
    step(9'd100, 9'd4, 1'b1);
    step(9'd8, 9'd7, 1'b1);
    step(9'd6, 9'd6, 1'b1);
    step(9'd200, 9'd200, 1'b1);
    step(9'd1, 9'd2, 1'b1);
    step(9'd0, 9'd0, 1'b0);
    @(posedge clk);
    #3 chk48("stats_321_u", {u_ltc, u_gtc, u_eqc}, {16'd1, 16'd3, 16'd2});
    chk48("stats_321_s", {s_ltc, s_gtc, s_eqc}, {16'd1, 16'd3, 16'd2});

    // Clear together with a valid compare: clear wins.
    step(9'd4, 9'd4, 1'b1, 1'b1);
    step(9'd0, 9'd0, 1'b0);
    @(posedge clk);
    #3 chk48("stats_clr_u", {u_ltc, u_gtc, u_eqc}, {16'd0, 16'd0, 16'd0});
    chk4("clr_flags_u", {u_ov, u_lt, u_gt, u_eq}, 4'b0001);

    // 65536 equal compares saturate eq_count.
    step(9'd3, 9'd3, 1'b1);
    repeat (65536) @(posedge clk);
    #2 in_valid = 1'b0;
    @(posedge clk);
    #3 chk48("stats_sat_u", {u_ltc, u_gtc, u_eqc}, {16'd0, 16'd0, 16'hFFFF});
    chk48("stats_sat_s", {s_ltc, s_gtc, s_eqc}, {16'd0, 16'd0, 16'hFFFF});
`endif

    repeat (2) @(posedge clk);
    #3;
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
